// File: rtl/wl_core_data_demux_pkg.sv
// Shared types and constants for the core data-side demultiplexer.
//   - reqrsp channel structs between the Snitch LSU and its data-side targets
//   - NAPOT address rules for DataMem, CSR and HWPE config
//   - target index enum (the last index is the internal error responder)
//   - read data returned on a decode error
package wl_core_data_demux_pkg;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic             write;
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic [1:0]       size;
  } core_data_req_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             error;
  } core_data_rsp_chan_t;

  typedef struct packed {
    core_data_req_chan_t q;
    logic                q_valid;
    logic                p_ready;
  } core_data_req_t;

  typedef struct packed {
    core_data_rsp_chan_t p;
    logic                p_valid;
    logic                q_ready;
  } core_data_rsp_t;

  typedef struct packed {
    logic [AddrW-1:0] base;
    logic [AddrW-1:0] offset;
  } addr_napot_demux_rule_t;

  typedef enum logic [1:0] {
    DATA_MEM = 2'd0,
    CSR      = 2'd1,
    HWPE_CFG = 2'd2,
    ERR      = 2'd3
  } wl_data_tgt_e;

  localparam logic [AddrW-1:0] DataMemBaseAddr = 32'h0000_0000;
  localparam logic [AddrW-1:0] DataMemOffset   = 32'h0001_0000;
  localparam logic [AddrW-1:0] CsrBaseAddr     = 32'h0002_0000;
  localparam logic [AddrW-1:0] CsrOffset       = 32'h0000_1000;
  localparam logic [AddrW-1:0] HwpeCfgBaseAddr = 32'h0003_0000;
  localparam logic [AddrW-1:0] HwpeCfgOffset   = 32'h0000_1000;

  localparam int unsigned DataDemuxNumRules = 3;

  // Rule index equals the target index (DATA_MEM, CSR, HWPE_CFG).
  localparam addr_napot_demux_rule_t DataDemuxRules [DataDemuxNumRules] = '{
    '{base: DataMemBaseAddr, offset: DataMemOffset},
    '{base: CsrBaseAddr,     offset: CsrOffset},
    '{base: HwpeCfgBaseAddr, offset: HwpeCfgOffset}
  };

  localparam logic [DataW-1:0] DataDemuxErrData = 32'hBADC_AB1E;

  // A zero-sized rule would otherwise match every address (mask of all ones
  // inverted to zero), so it is excluded explicitly.
  function automatic logic napot_match(input logic [AddrW-1:0] addr,
                                       input addr_napot_demux_rule_t rule);
    return (rule.offset != '0) &&
           ((addr & ~(rule.offset - AddrW'(1))) == rule.base);
  endfunction

endpackage

// File: rtl/wl_core_data_demux_order_fifo.sv
// wl_order_fifo: count-based FIFO remembering the target index of every
// outstanding request so responses can be returned in request order.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/data_i  write an entry (ignored when full)
//   pop_i/data_o   read port; data_o is the registered head entry
//   full_o/empty_o occupancy flags
// There is no fall-through: full_o depends only on the registered count.
module wl_order_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned    PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW:0]  DepthCnt = (PtrW + 1)'(Depth);

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    cnt_q, cnt_d;
  logic [Width-1:0] mem_q [Depth];
  logic             push_en, pop_en;

  assign full_o  = (cnt_q == DepthCnt);
  assign empty_o = (cnt_q == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Depth is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({push_en, pop_en})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push_i && full_o));

endmodule

// File: rtl/wl_core_data_demux.sv
// wl_core_data_demux: routes Snitch LSU reqrsp requests to DataMem, CSR and
// HWPE-cfg by NAPOT address rule; unmapped addresses get an internal error
// response. Responses return in request order via an order FIFO.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   slv_req_i/o    core side (q, q_valid, p_ready / p, p_valid, q_ready)
//   mst_req_o/i    one reqrsp port per target
//   busy_o         high while any transaction is outstanding
module wl_core_data_demux
  import wl_core_data_demux_pkg::*;
#(
  parameter int unsigned      MaxTrans   = 4,
  parameter int unsigned      NumTargets = DataDemuxNumRules,
  parameter logic [DataW-1:0] ErrData    = DataDemuxErrData
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  core_data_req_t                  slv_req_i,
  output core_data_rsp_t                  slv_rsp_o,
  output core_data_req_t [NumTargets-1:0] mst_req_o,
  input  core_data_rsp_t [NumTargets-1:0] mst_rsp_i,
  output logic                            busy_o
);

  localparam int unsigned     TgtW   = $clog2(NumTargets + 1);
  localparam logic [TgtW-1:0] ErrIdx = TgtW'(NumTargets);

  logic [TgtW-1:0]       sel, head;
  logic [TgtW-1:0]       last_q, last_d;
  logic                  fifo_full, fifo_empty;
  logic                  accept_pre, accept, tgt_q_ready, pop;
  logic [NumTargets-1:0] tgt_p_valid;

  // First matching rule wins; no match selects the error responder.
  always_comb begin
    sel = ErrIdx;
    for (int unsigned r = 0; r < DataDemuxNumRules; r++) begin
      if ((r < NumTargets) && (sel == ErrIdx) &&
          napot_match(slv_req_i.q.addr, DataDemuxRules[r])) begin
        sel = TgtW'(r);
      end
    end
  end

  // The error responder is always ready.
  always_comb begin
    tgt_q_ready = 1'b1;
    for (int unsigned t = 0; t < NumTargets; t++) begin
      if (sel == TgtW'(t)) tgt_q_ready = mst_rsp_i[t].q_ready;
    end
  end

  // A target switch waits for the FIFO to drain, otherwise two targets could
  // answer out of order. accept_pre excludes the target's q_ready so the
  // forwarded q_valid never depends on it.
  assign accept_pre = ~rst_i & slv_req_i.q_valid & ~fifo_full &
                      (fifo_empty | (sel == last_q));
  assign accept     = accept_pre & tgt_q_ready;

  assign last_d = accept ? sel : last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) last_q <= '0;
    else       last_q <= last_d;
  end

  wl_order_fifo #(
    .Depth (MaxTrans),
    .Width (TgtW)
  ) i_order_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Request forwarding and response muxing, both driven by the FIFO head.
  always_comb begin
    mst_req_o         = '0;
    slv_rsp_o         = '0;
    slv_rsp_o.q_ready = accept;
    for (int unsigned t = 0; t < NumTargets; t++) begin
      mst_req_o[t].q       = slv_req_i.q;
      mst_req_o[t].q_valid = accept_pre & (sel == TgtW'(t));
      mst_req_o[t].p_ready = ~rst_i & ~fifo_empty & (head == TgtW'(t)) &
                             slv_req_i.p_ready;
    end
    if (!rst_i && !fifo_empty) begin
      if (head == ErrIdx) begin
        slv_rsp_o.p_valid = 1'b1;
        slv_rsp_o.p.data  = ErrData;
        slv_rsp_o.p.error = 1'b1;
      end else begin
        for (int unsigned t = 0; t < NumTargets; t++) begin
          if (head == TgtW'(t)) begin
            slv_rsp_o.p       = mst_rsp_i[t].p;
            slv_rsp_o.p_valid = mst_rsp_i[t].p_valid;
          end
        end
      end
    end
  end

  assign pop    = slv_rsp_o.p_valid & slv_req_i.p_ready;
  assign busy_o = ~fifo_empty;

  always_comb begin
    tgt_p_valid = '0;
    for (int unsigned t = 0; t < NumTargets; t++) begin
      tgt_p_valid[t] = mst_rsp_i[t].p_valid;
    end
  end

  a_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (slv_req_i.q_valid && !slv_rsp_o.q_ready) |=> $stable(slv_req_i.q));

  a_no_rsp_when_idle: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_empty |-> (tgt_p_valid == '0));

endmodule
